// File: rtl/nios_avmm_pkg.sv
// Shared definitions for the Avalon-MM copy master: FSM state encoding,
// default bus widths and the byteenable constant.
package nios_avmm_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // Every transfer moves whole words, so all byte lanes are always enabled.
  localparam logic [DEF_DATA_W/8-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/nios_avmm_lat_cnt.sv
// Read-latency down-counter. Loaded on the read-acceptance edge and counted
// down while the master waits in CAPTURE; expired is high once READ_LATENCY
// cycles have elapsed since that edge.
module nios_avmm_lat_cnt #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Two bits cover the legal latency range 1..4 (load values 0..3).
  localparam logic [1:0] LOAD_VAL = 2'(READ_LATENCY - 1);

  logic [1:0] cnt;

  // Reload on acceptance, otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

  assign expired = (cnt == 2'd0);

endmodule

// File: rtl/nios_avmm_copy_master.sv
// Avalon-MM copy master: copies len words from src_addr to dst_addr, one
// read followed by one write per word.
//
// Handshake: a command (avm_read or avm_write) is accepted on a rising edge
// where it is high and avm_waitrequest is low; address, command and write
// data are held unchanged until that edge. Read data is taken exactly
// READ_LATENCY cycles after the read-acceptance edge.
//
// Optional feature: define NIOS_AVMM_COPY_CHECKSUM_EN to add a running
// modulo-2^DATA_W sum of the copied words on the checksum output.
module nios_avmm_copy_master
  import nios_avmm_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] COUNT_ZERO = '0;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [ADDR_W:0]     count;
  logic [DATA_W-1:0]   data_reg;

  logic                start_acc;
  logic                rd_acc;
  logic                wr_acc;
  logic                capture;
  logic                lat_expired;

  // State register; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and command outputs decoded from the current state.
  always_comb begin
    state_nxt   = state;
    start_acc   = 1'b0;
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    capture     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    avm_address = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (len == COUNT_ZERO) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        avm_read    = 1'b1;
        avm_address = src_ptr;
        if (!avm_waitrequest) begin
          rd_acc    = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (lat_expired) begin
          capture   = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        avm_write   = 1'b1;
        avm_address = dst_ptr;
        if (!avm_waitrequest) begin
          wr_acc    = 1'b1;
          state_nxt = (count == COUNT_ONE) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pointers, remaining count and the captured word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_reg <= '0;
    end else begin
      if (start_acc) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        count   <= len;
      end
      if (capture) begin
        data_reg <= avm_readdata;
      end
      if (wr_acc) begin
        // Pointers wrap naturally at 2^ADDR_W.
        src_ptr <= src_ptr + 1'b1;
        dst_ptr <= dst_ptr + 1'b1;
        count   <= count - 1'b1;
      end
    end
  end

  assign avm_writedata  = data_reg;
  assign avm_byteenable = {(DATA_W/8){&BE_ALL}};

  nios_avmm_lat_cnt #(
    .READ_LATENCY(READ_LATENCY)
  ) u_lat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (rd_acc),
    .en      (state == ST_CAPTURE),
    .expired (lat_expired)
  );

`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
  // Running sum of captured words, cleared when a new copy is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (start_acc) begin
      checksum <= '0;
    end else if (capture) begin
      checksum <= checksum + avm_readdata;
    end
  end
`endif

endmodule

// File: tb/tb_nios_avmm_copy_master.sv
// Bench for nios_avmm_copy_master (default parameters). A negedge slave
// model drives waitrequest/readdata and logs accepted commands; each test
// task compares the log against a word-level copy model.
module tb_nios_avmm_copy_master;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   src_addr;
  logic [AW-1:0]   dst_addr;
  logic [AW:0]     len;
  logic            busy;
  logic            done;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0]   avm_readdata;
  logic            avm_waitrequest;
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
  logic [DW-1:0]   checksum;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] rd_mem [DEPTH];
  logic [AW-1:0] obs_rd_q[$];
  logic [AW-1:0] obs_wr_addr_q[$];
  logic [DW-1:0] obs_wr_data_q[$];
  logic [DW-1:0] exp_q[$];

  // Slave model state.
  int            stall_mode  = 0;  // 0: never stall, 1: random, 2: two stalls per command
  int            stall_total = 0;
  int            viol        = 0;
  int            scnt        = 0;
  bit            pending_rd  = 0;
  logic [AW-1:0] paddr       = '0;
  bit            prev_stalled = 0;
  logic          prev_rd, prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  nios_avmm_copy_master dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: decides waitrequest for the current cycle, logs commands
  // that will be accepted on the coming edge, and presents read data in the
  // cycle after acceptance (latency 1); garbage otherwise.
  always @(negedge clk) begin
    logic cmd;
    if (pending_rd) begin
      avm_readdata = rd_mem[paddr];
      pending_rd   = 0;
    end else begin
      avm_readdata = $urandom;
    end
    cmd = avm_read | avm_write;
    if (avm_read && avm_write) viol++;
    if (prev_stalled) begin
      if (avm_read !== prev_rd || avm_write !== prev_wr || avm_address !== prev_addr ||
          (avm_write && avm_writedata !== prev_wdata)) viol++;
    end
    case (stall_mode)
      1: avm_waitrequest = ($urandom_range(0, 3) == 0);
      2: begin
        if (cmd && scnt < 2) begin
          avm_waitrequest = 1'b1;
          scnt++;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end
      default: avm_waitrequest = 1'b0;
    endcase
    prev_stalled = 0;
    if (cmd && avm_waitrequest) begin
      stall_total++;
      prev_stalled = 1;
      prev_rd      = avm_read;
      prev_wr      = avm_write;
      prev_addr    = avm_address;
      prev_wdata   = avm_writedata;
    end else if (cmd) begin
      scnt = 0;
      if (avm_read) begin
        obs_rd_q.push_back(avm_address);
        pending_rd = 1;
        paddr      = avm_address;
      end else begin
        obs_wr_addr_q.push_back(avm_address);
        obs_wr_data_q.push_back(avm_writedata);
      end
    end
    if (!reset_n) begin
      prev_stalled = 0;
      pending_rd   = 0;
    end
  end

  task automatic clear_logs();
    obs_rd_q.delete();
    obs_wr_addr_q.delete();
    obs_wr_data_q.delete();
    exp_q.delete();
    stall_total = 0;
    viol        = 0;
    scnt        = 0;
  endtask

  // Runs one copy and checks it against the word-level model.
  task automatic run_copy(input string name, input int n, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input int mode, input bit now,
                          output int done_cyc);
    int            k;
    int            bound;
    logic          busy1;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_sum;
    clear_logs();
    stall_mode = mode;
    if (!now) @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = (AW+1)'(n);
    @(negedge clk);
    start    = 1'b0;
    busy1    = busy;
    k        = 1;
    done_cyc = -1;
    bound    = 8 * n + 100;
    while (k <= bound) begin
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done_cyc != 3 * n + 1 + stall_total) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, 3 * n + 1 + stall_total);
    end
    n_cmp++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_cycle1: got %b expected 1", name, busy1);
    end
    if (done_cyc >= 0) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
      end
    end
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'(int'(s) + i);
      exp_q.push_back(rd_mem[a]);
      exp_sum = exp_sum + rd_mem[a];
    end
    n_cmp++;
    if (obs_rd_q.size() != n || obs_wr_addr_q.size() != n) begin
      n_fail++;
      $display("FAIL %s cmd_count: got reads=%0d writes=%0d expected %0d", name,
               obs_rd_q.size(), obs_wr_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < obs_rd_q.size(); i++) begin
      n_cmp++;
      if (obs_rd_q[i] !== AW'(int'(s) + i)) begin
        n_fail++;
        $display("FAIL %s rd_addr[%0d]: got %h expected %h", name, i, obs_rd_q[i], AW'(int'(s) + i));
      end
    end
    for (int i = 0; i < n && i < obs_wr_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_wr_addr_q[i] !== AW'(int'(d) + i) || obs_wr_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got %h/%h expected %h/%h", name, i, obs_wr_addr_q[i],
                 obs_wr_data_q[i], AW'(int'(d) + i), exp_q[i]);
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL %s cmd_stability: got %0d violations expected 0", name, viol);
    end
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
    n_cmp++;
    if (checksum !== exp_sum) begin
      n_fail++;
      $display("FAIL %s checksum: got %h expected %h", name, checksum, exp_sum);
    end
`endif
    stall_mode = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
        avm_address !== '0 || avm_writedata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h expected all 0",
               busy, done, avm_read, avm_write, avm_address, avm_writedata);
    end
    n_cmp++;
    if (avm_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL byteenable: got %h expected f", avm_byteenable);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_spec_example();
    int dc;
    run_copy("spec_len4", 4, 12'h010, 12'h100, 0, 0, dc);
    n_cmp++;
    if (dc != 13) begin
      n_fail++;
      $display("FAIL spec_len4_cycle13: got %0d expected 13", dc);
    end
  endtask

  task automatic test_zero_len();
    int dc;
    run_copy("zero_len", 0, 12'h0AB, 12'h0CD, 0, 0, dc);
    n_cmp++;
    if (dc != 1) begin
      n_fail++;
      $display("FAIL zero_len_cycle1: got %0d expected 1", dc);
    end
  endtask

  task automatic test_wrap();
    int dc;
    run_copy("wrap_len3", 3, 12'hFFE, 12'hFFF, 0, 0, dc);
  endtask

  task automatic test_stall();
    int dc;
    run_copy("stall_len2", 2, 12'h020, 12'h220, 2, 0, dc);
    n_cmp++;
    if (dc != 15) begin
      n_fail++;
      $display("FAIL stall_len2_cycle15: got %0d expected 15", dc);
    end
  endtask

  task automatic test_random();
    int dc;
    for (int r = 0; r < 6; r++) begin
      run_copy("random", $urandom_range(1, 8), AW'($urandom), AW'($urandom), 1, 0, dc);
    end
  endtask

  task automatic test_full_space();
    int dc;
    run_copy("full_space", DEPTH, 12'h123, 12'h456, 0, 0, dc);
  endtask

`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    int dc;
    rd_mem[12'h050] = 32'hFFFF_FFFF;
    rd_mem[12'h051] = 32'h0000_0002;
    run_copy("checksum_len2", 2, 12'h050, 12'h060, 0, 0, dc);
    n_cmp++;
    if (checksum !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL checksum_value: got %h expected 00000001", checksum);
    end
  endtask
`endif

  task automatic test_ignore_and_reset();
    int dc;
    bit saw_done;
    clear_logs();
    stall_mode = 0;
    @(negedge clk);
    start = 1'b1; src_addr = 12'h200; dst_addr = 12'h300; len = 13'd5;
    @(negedge clk);                           // cycle 1
    start = 1'b0;
    @(negedge clk);                           // cycle 2: CAPTURE, start ignored
    start = 1'b1; src_addr = 12'h400; dst_addr = 12'h500; len = 13'd1;
    @(negedge clk);                           // cycle 3
    start = 1'b0;
    repeat (3) @(negedge clk);                // cycle 6: second WRITE
    n_cmp++;
    if (avm_write !== 1'b1 || avm_address !== 12'h301) begin
      n_fail++;
      $display("FAIL mid_write: got wr=%b addr=%h expected 1 301", avm_write, avm_address);
    end
    n_cmp++;
    if (obs_rd_q.size() != 2 || obs_rd_q[0] !== 12'h200 || obs_rd_q[1] !== 12'h201) begin
      n_fail++;
      $display("FAIL ignored_start: got %0d reads, first %h expected 2 reads from 200",
               obs_rd_q.size(), (obs_rd_q.size() > 0) ? obs_rd_q[0] : 12'h0);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0 ||
        avm_address !== '0 || avm_writedata !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_write: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h expected all 0",
               busy, done, avm_read, avm_write, avm_address, avm_writedata);
    end
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
    n_cmp++;
    if (checksum !== '0) begin
      n_fail++;
      $display("FAIL reset_checksum: got %h expected 0", checksum);
    end
`endif
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got done pulse expected none");
    end
    // Release and start on the same negedge: the next edge must accept it.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_copy("start_after_reset", 1, 12'h7F0, 12'h7F8, 0, 1, dc);
    n_cmp++;
    if (dc != 4) begin
      n_fail++;
      $display("FAIL start_after_reset_cycle4: got %0d expected 4", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    run_copy("b2b_a", 2, 12'h030, 12'h130, 0, 1, dc);
    run_copy("b2b_b", 3, 12'h033, 12'h133, 1, 1, dc);
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    src_addr        = '0;
    dst_addr        = '0;
    len             = '0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < DEPTH; i++) rd_mem[i] = $urandom;

    test_reset();
    test_spec_example();
    test_zero_len();
    test_wrap();
    test_stall();
    test_random();
    test_back_to_back();
    test_full_space();
`ifdef NIOS_AVMM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    test_ignore_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_avmm_copy_master.md
NIOS_AVMM_COPY_MASTER -- requirements
Module: nios_avmm_copy_master

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the Avalon-MM master port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter READ_LATENCY, default 1, fixed slave read latency in cycles, legal range 1..4.
REQ-004 Port clk  input  1  sole clock; all logic is rising-edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle copy request, sampled only in IDLE.
REQ-007 Port src_addr  input  ADDR_W  first source word address, captured on an accepted start.
REQ-008 Port dst_addr  input  ADDR_W  first destination word address, captured on an accepted start.
REQ-009 Port len  input  ADDR_W+1  word count, 0..2^ADDR_W, captured on an accepted start.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port avm_address  output  ADDR_W  master word address.
REQ-013 Port avm_read / avm_write  output  1 each  read and write commands; never high together.
REQ-014 Port avm_writedata  output  DATA_W  write data.
REQ-015 Port avm_byteenable  output  DATA_W/8  held all-ones.
REQ-016 Port avm_readdata  input  DATA_W  slave read data.
REQ-017 Port avm_waitrequest  input  1  slave stall; a command is accepted in a cycle where it is high and waitrequest is low.

Function
REQ-018 FSM states: IDLE, READ, CAPTURE, WRITE, DONE.
REQ-019 IDLE with start=1: capture src_addr, dst_addr and len, then go to DONE if len=0, else READ; start while busy is ignored.
REQ-020 READ drives avm_read=1 and avm_address=src pointer, holding both stable until accepted; on acceptance go to CAPTURE.
REQ-021 CAPTURE waits READ_LATENCY-1 cycles, then registers avm_readdata exactly READ_LATENCY cycles after the acceptance edge and goes to WRITE.
REQ-022 WRITE drives avm_write=1, avm_address=dst pointer and avm_writedata=captured word, all held stable until accepted.
REQ-023 On write acceptance: increment both pointers modulo 2^ADDR_W, decrement the remaining count, then go to DONE if the count is 0, else READ.
REQ-024 DONE asserts done=1 for exactly one cycle, then goes to IDLE.
REQ-025 Timing with waitrequest tied low and READ_LATENCY=1: start sampled at edge 0 gives avm_read high in cycle 1 and done high in cycle 3*len+1.
REQ-026 Each waitrequest-high cycle during READ or WRITE adds exactly one cycle and has no other effect.
REQ-027 Pointers that reach 2^ADDR_W-1 wrap to 0 without error.
REQ-028 len=2^ADDR_W copies the entire address space.

Reset
REQ-029 Asserting reset_n low forces IDLE immediately.
REQ-030 Reset clears busy, done, avm_read, avm_write, avm_address, avm_writedata, all pointers, the count and the checksum to 0.
REQ-031 A transfer in progress at reset is abandoned with no done pulse.
REQ-032 After reset_n deasserts, the first start is accepted on the next edge.

Configuration
REQ-033 Macro NIOS_AVMM_COPY_CHECKSUM_EN, when defined, adds output checksum [DATA_W-1:0].
REQ-034 With the macro defined, checksum is cleared on an accepted start and updated with the modulo-2^DATA_W sum of every captured word; it is stable from the done pulse until the next accepted start.
REQ-035 Without the macro, the checksum port and its adder are absent and all other behaviour is identical.

Structure
REQ-036 Shared package nios_avmm_pkg holds the FSM state enum, the default ADDR_W/DATA_W localparams and the all-ones byteenable constant.
REQ-037 Sub-module nios_avmm_lat_cnt, a down-counter that signals when READ_LATENCY cycles have elapsed, is instantiated once by CAPTURE.

Verification
REQ-038 len=4, src=0x010, dst=0x100, waitrequest=0 -> reads at 0x010..0x013 then writes 0x100..0x103 interleaved with matching data, done in cycle 13.
REQ-039 len=0 -> no avm_read or avm_write, busy high in cycle 1 only, done pulse in cycle 1.
REQ-040 len=3, src=0xFFE, waitrequest=0 -> reads at 0xFFE, 0xFFF, 0x000.
REQ-041 len=2, waitrequest high 2 cycles on each command -> command signals stable while stalled, done in cycle 15.
REQ-042 start pulsed while busy -> ignored; then reset_n low mid-WRITE -> all outputs 0 and no done pulse.
REQ-043 Macro defined, len=2, data 0xFFFFFFFF and 0x00000002 -> checksum 0x00000001 at done.
